// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with show-ahead read data and registered status flags.
// Occupancy is tracked by a dedicated counter so full and empty never depend
// on comparing the read and write pointers. Overflow and underflow attempts
// are latched until the next flush or reset.
module fifo_sync_flags #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AFULL_LVL  = (1 << ASIZE) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_CNT  = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] AFULL_CNT  = AFULL_LVL[ASIZE:0];
    localparam logic [ASIZE:0] AEMPTY_CNT = AEMPTY_LVL[ASIZE:0];

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   waddr;
    logic [ASIZE:0]   raddr;
    logic [ASIZE:0]   count_next;
    logic             wr_ok;
    logic             rd_ok;

    // Accept decisions use only registered flags, so no flag ever has a
    // combinational path back from winc or rinc.
    assign wr_ok = winc && !wfull && !clr;
    assign rd_ok = rinc && !rempty && !clr;

    // Head of queue is presented without a read cycle.
    assign rdata = mem[raddr[ASIZE-1:0]];

    // Next occupancy: a simultaneous read and write leaves it unchanged.
    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Storage array; deliberately has no reset and is left intact by a flush.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr[ASIZE-1:0]] <= wdata;
        end
    end

    // Pointers, occupancy and all status flags, updated together each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr         <= '0;
            raddr         <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else if (clr) begin
            waddr         <= '0;
            raddr         <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (wr_ok) begin
                waddr <= waddr + 1'b1;
            end
            if (rd_ok) begin
                raddr <= raddr + 1'b1;
            end
            count         <= count_next;
            wfull         <= (count_next == DEPTH_CNT);
            rempty        <= (count_next == '0);
            walmost_full  <= (count_next >= AFULL_CNT);
            ralmost_empty <= (count_next <= AEMPTY_CNT);
            overflow      <= overflow  | (winc && wfull);
            underflow     <= underflow | (rinc && rempty);
        end
    end

    // The extra pointer bit makes the pointer distance equal to occupancy.
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
        (waddr - raddr) == count);

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed testbench for fifo_sync_flags with DEPTH=4, AFULL=3, AEMPTY=1.
module tb_fifo_sync_flags;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;
    logic       walmost_full;
    logic       ralmost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int vectors;
    int errors;

    fifo_sync_flags #(
        .DSIZE(8),
        .ASIZE(2),
        .AFULL_LVL(3),
        .AEMPTY_LVL(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .wdata(wdata),
        .winc(winc),
        .rinc(rinc),
        .rdata(rdata),
        .wfull(wfull),
        .rempty(rempty),
        .walmost_full(walmost_full),
        .ralmost_empty(ralmost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs, then return 1 ns after the edge with inputs idle.
    task automatic apply_stimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
        winc  = w;
        wdata = d;
        rinc  = r;
        clr   = c;
        @(posedge clk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
        clr  = 1'b0;
    endtask

    // Packed status word: {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow}
    function automatic logic [5:0] flags();
        return {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if (count !== 3'd0) begin
            $display("[TB] FAIL reset_count: got %0d want 0", count); errors++;
        end
        vectors++;
        if (flags() !== 6'b010100) begin
            $display("[TB] FAIL reset_flags: got %b want 010100", flags()); errors++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        logic [7:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [5:0] exp_f [4] = '{6'b000100, 6'b000000, 6'b001000, 6'b101000};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, data[i], 1'b0, 1'b0);
            vectors++;
            if (count !== 3'(i + 1)) begin
                $display("[TB] FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); errors++;
            end
            vectors++;
            if (flags() !== exp_f[i]) begin
                $display("[TB] FAIL fill_flags[%0d]: got %b want %b", i, flags(), exp_f[i]); errors++;
            end
        end
        vectors++;
        if (rdata !== 8'h11) begin
            $display("[TB] FAIL fill_head: got %h want 11", rdata); errors++;
        end
    endtask

    task automatic test_overflow_drain();
        logic [7:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
        vectors++;
        if (count !== 3'd4 || overflow !== 1'b1 || wfull !== 1'b1) begin
            $display("[TB] FAIL ovf_write: got count=%0d ovf=%b full=%b want 4 1 1",
                     count, overflow, wfull); errors++;
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rdata !== data[i]) begin
                $display("[TB] FAIL drain_data[%0d]: got %h want %h", i, rdata, data[i]); errors++;
            end
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        vectors++;
        if (count !== 3'd0 || flags() !== 6'b010110) begin
            $display("[TB] FAIL drain_end: got count=%0d flags=%b want 0 010110", count, flags()); errors++;
        end
    endtask

    task automatic test_full_rw();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h66, 1'b1, 1'b0);
        vectors++;
        if (count !== 3'd3 || overflow !== 1'b1 || rdata !== 8'h22) begin
            $display("[TB] FAIL full_rw: got count=%0d ovf=%b rdata=%h want 3 1 22",
                     count, overflow, rdata); errors++;
        end
        vectors++;
        if (flags() !== 6'b001010) begin
            $display("[TB] FAIL full_rw_flags: got %b want 001010", flags()); errors++;
        end
    endtask

    task automatic test_underflow();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (count !== 3'd0 || underflow !== 1'b1 || overflow !== 1'b0) begin
            $display("[TB] FAIL underflow: got count=%0d unf=%b ovf=%b want 0 1 0",
                     count, underflow, overflow); errors++;
        end
        apply_stimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        vectors++;
        if (count !== 3'd1 || rdata !== 8'hA5 || rempty !== 1'b0 || underflow !== 1'b1) begin
            $display("[TB] FAIL empty_rw: got count=%0d rdata=%h empty=%b unf=%b want 1 a5 0 1",
                     count, rdata, rempty, underflow); errors++;
        end
    endtask

    task automatic test_wrap_clr();
        // Pattern: w w w r w r w r -> reads 0x01,0x02,0x03; 0x04,0x05 remain.
        logic       op_w [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp_rd [3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] next_w;
        int         rd_idx;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        next_w = 8'h01;
        rd_idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (op_w[i]) begin
                apply_stimulus(1'b1, next_w, 1'b0, 1'b0);
                next_w = next_w + 8'h01;
            end else begin
                vectors++;
                if (rdata !== exp_rd[rd_idx]) begin
                    $display("[TB] FAIL wrap_read[%0d]: got %h want %h", rd_idx, rdata, exp_rd[rd_idx]); errors++;
                end
                apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
                rd_idx++;
            end
        end
        vectors++;
        if (count !== 3'd2 || rdata !== 8'h04) begin
            $display("[TB] FAIL wrap_end: got count=%0d rdata=%h want 2 04", count, rdata); errors++;
        end
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (rdata !== 8'h05 || count !== 3'd1) begin
            $display("[TB] FAIL wrap_tail: got rdata=%h count=%0d want 05 1", rdata, count); errors++;
        end
        apply_stimulus(1'b1, 8'h99, 1'b0, 1'b1);
        vectors++;
        if (count !== 3'd0 || flags() !== 6'b010100) begin
            $display("[TB] FAIL clr: got count=%0d flags=%b want 0 010100", count, flags()); errors++;
        end
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0);
        vectors++;
        if (count !== 3'd1 || rdata !== 8'h77) begin
            $display("[TB] FAIL clr_rewrite: got count=%0d rdata=%h want 1 77", count, rdata); errors++;
        end
    endtask

    task automatic test_async_reset();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hB3, 1'b0, 1'b0);
        vectors++;
        if (count !== 3'd3 || underflow !== 1'b1) begin
            $display("[TB] FAIL pre_reset: got count=%0d unf=%b want 3 1", count, underflow); errors++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd0 || flags() !== 6'b010100) begin
            $display("[TB] FAIL async_reset: got count=%0d flags=%b want 0 010100", count, flags()); errors++;
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        vectors++;
        if (count !== 3'd1 || rdata !== 8'hC3) begin
            $display("[TB] FAIL post_reset: got count=%0d rdata=%h want 1 c3", count, rdata); errors++;
        end
        vectors++;
        if (dut.mem[0] !== 8'hC3) begin
            $display("[TB] FAIL post_reset_addr0: got %h want c3", dut.mem[0]); errors++;
        end
    endtask

    // Scenario sequence.
    initial begin
        vectors = 0;
        errors  = 0;
        clr     = 1'b0;
        winc    = 1'b0;
        rinc    = 1'b0;
        wdata   = 8'h00;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_full_rw();
        test_underflow();
        test_wrap_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Safety net against a stalled simulation.
    initial begin
        #20000;
        $display("[TB] FAIL timeout: got no completion want completion by 20000 ns");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ASIZE, default 4, meaning address bits; DEPTH = 1<<ASIZE entries.
REQ-003 The block SHALL have parameter AFULL_LVL, default DEPTH-2, meaning almost-full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AEMPTY_LVL, default 2, meaning almost-empty threshold (1..DEPTH-1).
REQ-005 The block SHALL have port clk  input  1  single clock, all state on posedge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port clr  input  1  synchronous flush.
REQ-008 The block SHALL have port wdata  input  DSIZE  write data.
REQ-009 The block SHALL have port winc  input  1  write request.
REQ-010 The block SHALL have port rinc  input  1  read request.
REQ-011 The block SHALL have port rdata  output  DSIZE  head-of-queue data (show-ahead).
REQ-012 The block SHALL have port wfull  output  1  count == DEPTH.
REQ-013 The block SHALL have port rempty  output  1  count == 0.
REQ-014 The block SHALL have port walmost_full  output  1  count >= AFULL_LVL.
REQ-015 The block SHALL have port ralmost_empty  output  1  count <= AEMPTY_LVL.
REQ-016 The block SHALL have port count  output  ASIZE+1  current occupancy, 0..DEPTH.
REQ-017 The block SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-018 The block SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 A write SHALL be accepted iff winc && !wfull && !clr; accepted write stores wdata at waddr, waddr wraps DEPTH-1 -> 0.
REQ-020 A read SHALL be accepted iff rinc && !rempty && !clr; raddr advances with wrap DEPTH-1 -> 0.
REQ-021 rdata SHALL equal mem[raddr] combinationally (zero-cycle show-ahead); value undefined while rempty=1.
REQ-022 Pointers SHALL be ASIZE+1 bits binary; full/empty SHALL NOT be derived from pointer equality alone but from registered count.
REQ-023 count next SHALL be: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-024 wfull, rempty, walmost_full, ralmost_empty SHALL be registered, updated in the same cycle as count, no combinational path from winc/rinc.
REQ-025 Full with winc && rinc: read accepted, write rejected, overflow set, count -> DEPTH-1.
REQ-026 Empty with winc && rinc: write accepted, read rejected, underflow set, count -> 1; data readable next cycle.
REQ-027 overflow/underflow SHALL stay 1 until clr or reset.
REQ-028 clr SHALL take priority over winc/rinc: next cycle pointers=0, count=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0, overflow=underflow=0; memory contents untouched.
REQ-029 Write-to-read latency SHALL be 1 cycle: data written at edge N is visible on rdata with rempty=0 after edge N.

Reset
REQ-030 rst_n low SHALL asynchronously force pointers=0, count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, overflow=0, underflow=0; memory not reset.
REQ-031 Reset asserted mid-transfer SHALL discard all queued data; first accepted write after deassertion lands at address 0.

Verification (DSIZE=8, ASIZE=2, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-032 Write 0x11,0x22,0x33,0x44 back-to-back -> count 1,2,3,4; walmost_full at count 3; wfull=1 after 4th; rdata=0x11.
REQ-033 From full, winc=1 with 0x55 -> write dropped, overflow=1, count=4; then 4 reads -> rdata 0x11,0x22,0x33,0x44, rempty=1.
REQ-034 From full, winc && rinc one cycle -> count=3, overflow=1, rdata=0x22.
REQ-035 Empty, rinc=1 -> underflow=1, count=0; then winc && rinc with 0xA5 -> count=1, rdata=0xA5 next cycle.
REQ-036 Write 5 words interleaved with 3 reads to force wrap -> read order preserved, count=2; assert clr with winc=1 -> count=0, rempty=1, flags cleared, write dropped.
REQ-037 Assert rst_n=0 between clock edges with count=3 -> outputs reach reset values immediately, before next clk edge.
